// File: rtl/flash_loader.sv
// Boot-time program loader: receives a framed byte stream, assembles
// little-endian 32-bit words, writes them to sequential instruction-memory
// addresses and holds the CPU until the image checksum has been verified.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   byte_valid/data     incoming stream byte
//   byte_ready          loader accepts a byte this cycle
//   reload              restart request (honoured in DONE/ERR only)
//   flash_en/addr/data  registered single-cycle write port to the datapath
//   cpu_hold            CPU held in reset while high
//   done, error         image verified / bad length or checksum (sticky)
//   words_written       words written in the current load
module flash_loader #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  input  logic                  reload,
  output logic                  flash_en,
  output logic [ADDR_WIDTH-1:0] flash_addr,
  output logic [WIDTH-1:0]      flash_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_written
);

  localparam int unsigned WW_W      = ADDR_WIDTH + 1;
  localparam int unsigned MAX_WORDS = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t                  state_q, state_n;
  logic [15:0]             len_q, len_n;
  logic [23:0]             lane_q, lane_n;
  logic [1:0]              lane_cnt_q, lane_cnt_n;
  logic [7:0]              csum_q, csum_n;
  logic [WW_W-1:0]         ww_q, ww_n;
  logic                    flash_en_n;
  logic [ADDR_WIDTH-1:0]   flash_addr_n;
  logic [WIDTH-1:0]        flash_data_n;
  logic                    xfer;

  // Ready is gated by reset so nothing is taken while the loader is held.
  always_comb begin
    byte_ready = 1'b0;
    case (state_q)
      S_LEN_LO, S_LEN_HI, S_DATA, S_CHK: byte_ready = rst;
      default:                           byte_ready = 1'b0;
    endcase
  end

  assign xfer          = byte_valid && byte_ready;
  assign words_written = ww_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_LEN_LO;
      len_q      <= '0;
      lane_q     <= '0;
      lane_cnt_q <= '0;
      csum_q     <= '0;
      ww_q       <= '0;
      flash_en   <= 1'b0;
      flash_addr <= '0;
      flash_data <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_hold   <= 1'b1;
    end else begin
      state_q    <= state_n;
      len_q      <= len_n;
      lane_q     <= lane_n;
      lane_cnt_q <= lane_cnt_n;
      csum_q     <= csum_n;
      ww_q       <= ww_n;
      flash_en   <= flash_en_n;
      flash_addr <= flash_addr_n;
      flash_data <= flash_data_n;
      done       <= (state_n == S_DONE);
      error      <= (state_n == S_ERR);
      cpu_hold   <= (state_n != S_DONE);
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_n      = state_q;
    len_n        = len_q;
    lane_n       = lane_q;
    lane_cnt_n   = lane_cnt_q;
    csum_n       = csum_q;
    ww_n         = ww_q;
    flash_en_n   = 1'b0;
    flash_addr_n = flash_addr;
    flash_data_n = flash_data;

    case (state_q)
      S_LEN_LO: begin
        if (xfer) begin
          len_n   = {8'h00, byte_data};
          state_n = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_n = {byte_data, len_q[7:0]};
          if (len_n == 16'h0000)               state_n = S_CHK;
          else if (32'(len_n) > MAX_WORDS)     state_n = S_ERR;
          else                                 state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          csum_n     = csum_q ^ byte_data;
          lane_cnt_n = lane_cnt_q + 2'd1;
          case (lane_cnt_q)
            2'd0:    lane_n[7:0]   = byte_data;
            2'd1:    lane_n[15:8]  = byte_data;
            2'd2:    lane_n[23:16] = byte_data;
            default: begin
              // Lane 3 completes the word: register the write for next cycle.
              flash_en_n   = 1'b1;
              flash_addr_n = ww_q[ADDR_WIDTH-1:0];
              flash_data_n = WIDTH'({byte_data, lane_q});
              state_n      = S_WRITE;
            end
          endcase
        end
      end
      S_WRITE: begin
        // words_written doubles as the write index; it stops at the length.
        ww_n = ww_q + WW_W'(1);
        if (32'(ww_n) == 32'(len_q)) state_n = S_CHK;
        else                         state_n = S_DATA;
      end
      S_CHK: begin
        if (xfer) state_n = (byte_data == csum_q) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: begin
        if (reload) begin
          state_n    = S_LEN_LO;
          len_n      = '0;
          lane_n     = '0;
          lane_cnt_n = '0;
          csum_n     = '0;
          ww_n       = '0;
        end
      end
      default: state_n = S_LEN_LO;
    endcase
  end

endmodule

// File: tb/tb_flash_loader.sv
module tb_flash_loader;

  typedef logic [31:0] wq_t[$];
  typedef struct packed {
    logic [10:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        reload;
  logic        flash_en;
  logic [10:0] flash_addr;
  logic [31:0] flash_data;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [11:0] words_written;

  int  checks = 0;
  int  errors = 0;
  wr_t sb[$];

  flash_loader #(.WIDTH(32), .ADDR_WIDTH(11)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .reload(reload), .flash_en(flash_en),
    .flash_addr(flash_addr), .flash_data(flash_data), .cpu_hold(cpu_hold),
    .done(done), .error(error), .words_written(words_written)
  );

  always #5 clk = ~clk;

  // Every write strobe must match the next expected write, in order.
  always @(negedge clk) begin
    if (flash_en === 1'b1) begin
      wr_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%08h", flash_addr, flash_data);
      end else begin
        e = sb.pop_front();
        if (flash_addr !== e.addr || flash_data !== e.data) begin
          errors++;
          $display("FAIL write got addr=%0h data=%08h exp addr=%0h data=%08h",
                   flash_addr, flash_data, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input int maxw,
                           output bit ok, output int waited);
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    waited     = 0;
    while (!byte_ready && waited < maxw) begin
      @(negedge clk);
      waited++;
    end
    ok = byte_ready;
    if (ok) @(negedge clk);
    byte_valid = 1'b0;
  endtask

  // Builds a frame from words, queues the expected writes and streams it.
  task automatic load(input wq_t words, input int gapmax, input logic [7:0] flip,
                      output int timeouts, output int waits);
    logic [7:0] f[$];
    logic [7:0] cs = 8'h00;
    logic [7:0] bb;
    logic [31:0] w32;
    bit ok;
    int w;
    f.push_back(8'(words.size()));
    f.push_back(8'(words.size() >> 8));
    foreach (words[i]) begin
      w32 = words[i];
      for (int k = 0; k < 4; k++) begin
        bb = w32[8*k +: 8];
        f.push_back(bb);
        cs ^= bb;
      end
      sb.push_back({11'(i), w32});
    end
    f.push_back(cs ^ flip);
    timeouts = 0;
    waits    = 0;
    foreach (f[j]) begin
      send_byte(f[j], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0, 20, ok, w);
      if (!ok) timeouts++;
      waits += w;
    end
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; byte_valid = 1'b1; byte_data = 8'h55; reload = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", byte_ready); end
    checks++;
    if ({flash_en, flash_addr, flash_data, done, error, words_written, cpu_hold} !==
        {1'b0, 11'h0, 32'h0, 1'b0, 1'b0, 12'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs en=%b a=%0h d=%h done=%b err=%b ww=%0d hold=%b",
               flash_en, flash_addr, flash_data, done, error, words_written, cpu_hold);
    end
    byte_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%b exp=1", byte_ready); end
  endtask

  task automatic test_two_word();
    int to, wt;
    wq_t ws = '{32'h00000013, 32'h000000B3};
    load(ws, 0, 8'h00, to, wt);
    checks++;
    if (to !== 0) begin errors++; $display("FAIL two_word_timeouts got=%0d exp=0", to); end
    // Byte offered during each WRITE cycle waits exactly one cycle.
    checks++;
    if (wt !== 2) begin errors++; $display("FAIL two_word_write_stall got=%0d exp=2", wt); end
    checks++;
    if ({done, cpu_hold, error, words_written} !== {1'b1, 1'b0, 1'b0, 12'd2}) begin
      errors++;
      $display("FAIL two_word_status done=%b hold=%b err=%b ww=%0d exp 1 0 0 2",
               done, cpu_hold, error, words_written);
    end
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL two_word_pending got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_bad_checksum();
    int to, wt, w;
    bit ok;
    wq_t ws = '{32'h00000013, 32'h000000B3};
    load(ws, 0, 8'h01, to, wt);
    checks++;
    if ({done, cpu_hold, error, words_written} !== {1'b0, 1'b1, 1'b1, 12'd2} || to !== 0) begin
      errors++;
      $display("FAIL bad_csum_status done=%b hold=%b err=%b ww=%0d to=%0d exp 0 1 1 2 0",
               done, cpu_hold, error, words_written, to);
    end
    send_byte(8'h00, 0, 5, ok, w);
    checks++;
    if (ok !== 1'b0 || error !== 1'b1) begin
      errors++;
      $display("FAIL bad_csum_accepts got ok=%b err=%b exp ok=0 err=1", ok, error);
    end
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL bad_csum_pending got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_length();
    int to, wt, w;
    bit ok1, ok2;
    wq_t none = {};
    send_byte(8'h01, 0, 20, ok1, w);
    send_byte(8'h08, 0, 20, ok2, w);
    @(negedge clk);
    checks++;
    if ({ok1, ok2, error, done, cpu_hold, words_written} !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'd0}) begin
      errors++;
      $display("FAIL oversize got ok=%b%b err=%b done=%b hold=%b ww=%0d exp 11 1 0 1 0",
               ok1, ok2, error, done, cpu_hold, words_written);
    end
    do_reload();
    load(none, 0, 8'h00, to, wt);
    checks++;
    if ({done, error, cpu_hold, words_written} !== {1'b1, 1'b0, 1'b0, 12'd0} || to !== 0) begin
      errors++;
      $display("FAIL zero_len got done=%b err=%b hold=%b ww=%0d to=%0d exp 1 0 0 0 0",
               done, error, cpu_hold, words_written, to);
    end
  endtask

  task automatic test_back_to_back_gaps();
    int to, wt;
    wq_t ws = '{32'h11223344, 32'hA5A55A5A, 32'h00FF00FF};
    load(ws, 3, 8'h00, to, wt);
    checks++;
    if ({done, error, words_written} !== {1'b1, 1'b0, 12'd3} || to !== 0 || sb.size() !== 0) begin
      errors++;
      $display("FAIL gaps got done=%b err=%b ww=%0d to=%0d pend=%0d exp 1 0 3 0 0",
               done, error, words_written, to, sb.size());
    end
  endtask

  task automatic test_reload();
    int to, wt;
    wq_t ws = '{32'hDEADBEEF};
    do_reload();
    checks++;
    if ({cpu_hold, done, error, words_written, byte_ready} !== {1'b1, 1'b0, 1'b0, 12'd0, 1'b1}) begin
      errors++;
      $display("FAIL reload_state hold=%b done=%b err=%b ww=%0d rdy=%b exp 1 0 0 0 1",
               cpu_hold, done, error, words_written, byte_ready);
    end
    load(ws, 0, 8'h00, to, wt);
    checks++;
    if ({done, cpu_hold, words_written} !== {1'b1, 1'b0, 12'd1} || to !== 0 || sb.size() !== 0) begin
      errors++;
      $display("FAIL reload_load done=%b hold=%b ww=%0d to=%0d pend=%0d exp 1 0 1 0 0",
               done, cpu_hold, words_written, to, sb.size());
    end
  endtask

  task automatic test_mid_reset();
    int to, wt, w;
    bit ok;
    logic [7:0] pre[4] = '{8'h02, 8'h00, 8'h13, 8'h00};
    wq_t ws = '{32'hDEADBEEF};
    do_reload();
    foreach (pre[i]) send_byte(pre[i], 0, 20, ok, w);
    rst = 1'b0;
    byte_valid = 1'b1;
    byte_data = 8'h77;
    #1;
    checks++;
    if (byte_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got=%b exp=0", byte_ready); end
    @(negedge clk);
    checks++;
    if ({flash_en, flash_addr, flash_data, done, error, words_written, cpu_hold} !==
        {1'b0, 11'h0, 32'h0, 1'b0, 1'b0, 12'h0, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset_outputs en=%b a=%0h d=%h done=%b err=%b ww=%0d hold=%b",
               flash_en, flash_addr, flash_data, done, error, words_written, cpu_hold);
    end
    byte_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    load(ws, 0, 8'h00, to, wt);
    checks++;
    if ({done, error, words_written} !== {1'b1, 1'b0, 12'd1} || to !== 0 || sb.size() !== 0) begin
      errors++;
      $display("FAIL mid_reset_reload done=%b err=%b ww=%0d to=%0d pend=%0d exp 1 0 1 0 0",
               done, error, words_written, to, sb.size());
    end
  endtask

  task automatic test_full_image();
    int to, wt;
    wq_t ws;
    for (int i = 0; i < 2048; i++) ws.push_back(32'(i) * 32'h9E3779B1);
    do_reload();
    load(ws, 0, 8'h00, to, wt);
    checks++;
    if ({done, error, words_written, flash_addr} !== {1'b1, 1'b0, 12'd2048, 11'd2047} ||
        to !== 0 || sb.size() !== 0) begin
      errors++;
      $display("FAIL full_image done=%b err=%b ww=%0d last=%0d to=%0d pend=%0d exp 1 0 2048 2047 0 0",
               done, error, words_written, flash_addr, to, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_two_word();
    do_reload();
    test_bad_checksum();
    do_reload();
    test_length();
    do_reload();
    test_back_to_back_gaps();
    test_reload();
    test_mid_reset();
    test_full_image();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
